// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: write-back arbiter for the single register-file write port.
// ALU results are written with one cycle of latency; LSU results are queued
// in a small FIFO and drained when the ALU is idle, or forcibly after the
// FIFO head has lost STARVE_MAX consecutive cycles to the ALU.
// A 32-bit mask reports destinations still queued or on the output registers.
// Optional feature macro: WB_LSU_BYPASS_EN (LSU result skips an empty FIFO
// when the port is otherwise free).
module regfile_wb_arb #(
  parameter int XLEN       = 32,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      alu_valid_i,
  input  logic [4:0]                alu_rd_addr_i,
  input  logic [XLEN-1:0]           alu_rd_data_i,
  output logic                      alu_stall_o,
  input  logic                      lsu_valid_i,
  output logic                      lsu_ready_o,
  input  logic [4:0]                lsu_rd_addr_i,
  input  logic [XLEN-1:0]           lsu_rd_data_i,
  output logic                      rd_we_o,
  output logic [4:0]                rd_addr_o,
  output logic [XLEN-1:0]           rd_data_o,
  output logic [31:0]               pend_mask_o,
  output logic [$clog2(LQ_DEPTH):0] lq_cnt_o
);

  localparam int AW = $clog2(LQ_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(LQ_DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  // FIFO storage and pointers
  logic [XLEN-1:0] r_q_data [LQ_DEPTH];
  logic [4:0]      r_q_addr [LQ_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_cnt;

  // Arbitration state and output registers
  logic [SW-1:0]   r_starve;
  logic            r_stall;
  logic            r_we;
  logic            r_from_lsu;
  logic [4:0]      r_addr;
  logic [XLEN-1:0] r_data;
  logic [31:0]     r_pend;

  // Combinational decisions for the current cycle
  logic            w_empty;
  logic            w_ready;
  logic            w_push_hs;
  logic            w_enq;
  logic            w_pop;
  logic            w_alu_win;
  logic            w_bypass;
  logic            w_nxt_we;
  logic            w_nxt_lsu;
  logic [4:0]      w_nxt_addr;
  logic [XLEN-1:0] w_nxt_data;
  logic [SW-1:0]   w_starve_nxt;
  logic [31:0]     w_pend_nxt;

  // Priority arbitration: forced pop, then ALU, then FIFO head, then bypass
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    w_empty   = (r_cnt == '0);
    w_ready   = (r_cnt != FULL_CNT);
    w_push_hs = lsu_valid_i & w_ready;
    w_pop     = 1'b0;
    w_alu_win = 1'b0;
    w_bypass  = 1'b0;
    if (r_stall) begin
      w_pop = !w_empty;
    end else if (alu_valid_i) begin
      w_alu_win = 1'b1;
    end else if (!w_empty) begin
      w_pop = 1'b1;
    end
`ifdef WB_LSU_BYPASS_EN
    else if (lsu_valid_i) begin
      w_bypass = 1'b1;
    end
`endif
    // Writes to x0 are accepted but never queued.
    w_enq = w_push_hs & (lsu_rd_addr_i != 5'd0) & !w_bypass;
  end

  // Next contents of the write-port registers
  always_comb begin
    w_nxt_we   = 1'b0;
    w_nxt_lsu  = 1'b0;
    w_nxt_addr = 5'd0;
    w_nxt_data = '0;
    if (w_pop) begin
      w_nxt_we   = 1'b1;
      w_nxt_lsu  = 1'b1;
      w_nxt_addr = r_q_addr[r_rd_ptr];
      w_nxt_data = r_q_data[r_rd_ptr];
    end else if (w_alu_win) begin
      w_nxt_we   = (alu_rd_addr_i != 5'd0);
      w_nxt_addr = alu_rd_addr_i;
      w_nxt_data = alu_rd_data_i;
    end else if (w_bypass) begin
      w_nxt_we   = (lsu_rd_addr_i != 5'd0);
      w_nxt_lsu  = (lsu_rd_addr_i != 5'd0);
      w_nxt_addr = lsu_rd_addr_i;
      w_nxt_data = lsu_rd_data_i;
    end
  end

  // Starvation counter and pending-destination mask next values
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || w_empty) begin
      w_starve_nxt = '0;
    end else if (w_alu_win) begin
      w_starve_nxt = r_starve + SW'(1);
    end

    w_pend_nxt = r_pend;
    // An LSU write leaves the mask once it has sat one cycle on the port.
    if (r_we && r_from_lsu) begin
      w_pend_nxt[r_addr] = 1'b0;
    end
    if (w_enq) begin
      w_pend_nxt[lsu_rd_addr_i] = 1'b1;
    end
    if (w_bypass && (lsu_rd_addr_i != 5'd0)) begin
      w_pend_nxt[lsu_rd_addr_i] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  // FIFO payload storage
  always_ff @(posedge clk_i) begin
    // NOTE: the payload array is left unreset; r_cnt and the pointers alone decide which entries are valid.
    if (w_enq) begin
      r_q_data[r_wr_ptr] <= lsu_rd_data_i;
      r_q_addr[r_wr_ptr] <= lsu_rd_addr_i;
    end
  end

  // Control state, output registers and mask with synchronous reset
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_stall    <= 1'b0;
      r_we       <= 1'b0;
      r_from_lsu <= 1'b0;
      r_addr     <= 5'd0;
      r_data     <= '0;
      r_pend     <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt      <= r_cnt + CW'(w_enq) - CW'(w_pop);
      r_starve   <= w_starve_nxt;
      r_stall    <= (w_starve_nxt == STARVE_LIM);
      r_we       <= w_nxt_we;
      r_from_lsu <= w_nxt_lsu;
      r_addr     <= w_nxt_addr;
      r_data     <= w_nxt_data;
      r_pend     <= w_pend_nxt;
    end
  end

  // Upstream hazard protocol checks (simulation assertions)
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (!(w_push_hs && (lsu_rd_addr_i != 5'd0) && r_pend[lsu_rd_addr_i]));
      assert (!(alu_valid_i && !r_stall && (alu_rd_addr_i != 5'd0) && r_pend[alu_rd_addr_i]));
    end
  end

  assign alu_stall_o = r_stall;
  assign lsu_ready_o = (r_cnt != FULL_CNT);
  assign rd_we_o     = r_we;
  assign rd_addr_o   = r_addr;
  assign rd_data_o   = r_data;
  assign pend_mask_o = r_pend;
  assign lq_cnt_o    = r_cnt;

endmodule
